// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multi-cycle MIPS controller.
//   Opcode values decoded in DECODE, 4-bit state encodings, the mux-select
//   and ALU-op codes driven to the datapath, the trap-cause codes, and the
//   control-word bundle produced by the state decode.
package mc_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // State encodings (also visible on state_out)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operation to ALUControl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Datapath control bundle produced by the state decode
  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSource;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
  } ctrlWord_t;

  function automatic logic isSupported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for mem_ready and flags a
//   timeout when the count reaches MEM_TIMEOUT with no ready this cycle.
//   MEM_TIMEOUT = 0 disables the timeout.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   clear     zero the count (controller is changing state)
//   waiting   controller is in a state that waits on mem_ready
//   memReady  memory completes the access this cycle
//   timeout   waiting, no ready, and the count has hit MEM_TIMEOUT
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  input  logic memReady,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] waitCount;

  // The count stops at LIMIT, so with the timeout disabled it simply sits at 0.
  always_ff @(posedge clk) begin
    if (rst || clear || memReady) begin
      waitCount <= '0;
    end else if (waiting && (waitCount != LIMIT)) begin
      waitCount <= waitCount + CW'(1);
    end
  end

  assign timeout = (MEM_TIMEOUT > 0) && waiting && !memReady && (waitCount == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB)
//   for R-type, lw, sw, beq, j and addi, with a mem_ready handshake and
//   memory-wait timeout trap.
// Build option: define MC_CTRL_ILLEGAL_TRAP_EN to trap on unsupported opcodes;
//   otherwise an unsupported opcode retires as a NOP.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   opcode                IR[31:26], valid from DECODE onward
//   alu_zero, mem_ready   ALU zero flag; memory access completes this cycle
//   mem_read, mem_write   memory requests
//   i_or_d                memory address from PC (0) or ALUOut (1)
//   ir_write, pc_write    IR / PC load enables
//   pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg   datapath selects
//   reg_write             register file write enable
//   state_out             current state encoding (debug)
//   trap, trap_cause      trap flag and cause (01 illegal, 10 timeout)
//   instr_count           instructions retired since reset (wraps)
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [3:0]       state_out,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_count
);

  logic [3:0]       state, nextState;
  logic [1:0]       trapCause, nextCause;
  logic [CNT_W-1:0] instrCount;
  logic             retire;
  logic             waiting;
  logic             timeout;
  ctrlWord_t        ctrl;

  assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  // Any state change clears the wait count, which covers every entry into a waiting state.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) uWaitTimer (
    .clk      (clk),
    .rst      (rst),
    .clear    (nextState != state),
    .waiting  (waiting),
    .memReady (mem_ready),
    .timeout  (timeout)
  );

  // Next-state, retire and trap-cause logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    nextState = state;
    nextCause = trapCause;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (timeout) begin
          nextState = S_TRAP;
          nextCause = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!isSupported(opcode)) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          nextState = S_TRAP;
          nextCause = CAUSE_ILLEGAL;
`else
          nextState = S_FETCH;
          retire    = 1'b1;
`endif
        end else begin
          case (opcode)
            OP_RTYPE:      nextState = S_EXEC;
            OP_LW, OP_SW:  nextState = S_MEMADR;
            OP_BEQ:        nextState = S_BRANCH;
            OP_J:          nextState = S_JUMP;
            default:       nextState = S_ADDIEX;
          endcase
        end
      end
      S_MEMADR: nextState = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (timeout) begin
          nextState = S_TRAP;
          nextCause = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          nextState = S_MEMWB;
        end
      end
      S_MEMWR: begin
        if (timeout) begin
          nextState = S_TRAP;
          nextCause = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          nextState = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_EXEC:   nextState = S_RWB;
      S_ADDIEX: nextState = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        nextState = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP:   nextState = S_TRAP;
      default:  nextState = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state      <= S_FETCH;
      trapCause  <= CAUSE_NONE;
      instrCount <= '0;
    end else begin
      state     <= nextState;
      trapCause <= nextCause;
      if (retire) begin
        instrCount <= instrCount + CNT_W'(1);
      end
    end
  end

  // Moore decode of the state; FETCH and BRANCH gate their PC/IR loads
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALUOP_ADD;
        ctrl.pcSource = PCSRC_ALU;
        ctrl.irWrite = mem_ready;
        ctrl.pcWrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.aluSrcB = SRCB_IMM_SH;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iOrD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
      end
      S_MEMWR: begin
        // A timed-out store must not be committed to memory.
        ctrl.memWrite = !timeout;
        ctrl.iOrD     = 1'b1;
      end
      S_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REG;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      S_ADDIWB: ctrl.regWrite = 1'b1;
      S_BRANCH: begin
        ctrl.aluSrcA  = 1'b1;
        ctrl.aluSrcB  = SRCB_REG;
        ctrl.aluOp    = ALUOP_SUB;
        ctrl.pcSource = PCSRC_ALUOUT;
        ctrl.pcWrite  = alu_zero;
      end
      S_JUMP: begin
        ctrl.pcSource = PCSRC_JUMP;
        ctrl.pcWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are masked by rst combinationally so a reset mid-handshake drops them at once.
  assign mem_read    = ctrl.memRead  & ~rst;
  assign mem_write   = ctrl.memWrite & ~rst;
  assign ir_write    = ctrl.irWrite  & ~rst;
  assign pc_write    = ctrl.pcWrite  & ~rst;
  assign reg_write   = ctrl.regWrite & ~rst;
  assign i_or_d      = ctrl.iOrD;
  assign pc_source   = ctrl.pcSource;
  assign alu_src_a   = ctrl.aluSrcA;
  assign alu_src_b   = ctrl.aluSrcB;
  assign alu_op      = ctrl.aluOp;
  assign reg_dst     = ctrl.regDst;
  assign mem_to_reg  = ctrl.memToReg;
  assign state_out   = state;
  assign trap        = (state == S_TRAP);
  assign trap_cause  = trapCause;
  assign instr_count = instrCount;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
//   Each instruction is expanded into its expected per-cycle step list from
//   the instruction rules; the bench then drives that list and checks state,
//   control outputs, trap status and the retired-instruction count.
module tb_multicycle_ctrl;

  localparam int CNT_W = 8;
  localparam int TMO   = 3;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic alu_zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_read, mem_write, i_or_d, ir_write, pc_write, alu_src_a;
  logic reg_dst, mem_to_reg, reg_write, trap;
  logic [1:0] pc_source, alu_src_b, alu_op, trap_cause;
  logic [3:0] state_out;
  logic [CNT_W-1:0] instr_count;

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .state_out(state_out), .trap(trap), .trap_cause(trap_cause), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic memRead, memWrite, iOrD, irWrite, pcWrite;
    logic [1:0] pcSource;
    logic aluSrcA;
    logic [1:0] aluSrcB, aluOp;
    logic regDst, memToReg, regWrite;
  } ctrl_t;

  typedef struct {
    int         st;
    logic       mr;
    logic       az;
    logic       retire;
    logic [5:0] op;
  } step_t;

  ctrl_t obsCtrl;
  assign obsCtrl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
                    alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write};

  int checks = 0;
  int errors = 0;
  int modelCount = 0;
  step_t trace[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit isLegal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, JMP, ADDI};
  endfunction

  // Control outputs expected for each named step of the instruction flow
  function automatic ctrl_t expCtrl(input int st, input logic mr, input logic az);
    ctrl_t c = '0;
    case (st)
      0:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = mr; c.pcWrite = mr; end
      1:  c.aluSrcB = 2'b11;
      2:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      3:  begin c.memRead = 1; c.iOrD = 1; end
      4:  begin c.regWrite = 1; c.memToReg = 1; end
      5:  begin c.memWrite = 1; c.iOrD = 1; end
      6:  begin c.aluSrcA = 1; c.aluOp = 2'b10; end
      7:  begin c.regWrite = 1; c.regDst = 1; end
      8:  begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcSource = 2'b01; c.pcWrite = az; end
      9:  begin c.pcSource = 2'b10; c.pcWrite = 1; end
      10: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      11: c.regWrite = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic pushStep(input int st, input logic mr, input logic ret, input int az,
                          input logic [5:0] op);
    step_t s;
    s.st = st;
    s.mr = mr;
    s.az = (az < 0) ? logic'($urandom_range(1)) : logic'(az);
    s.retire = ret;
    s.op = op;
    trace.push_back(s);
  endtask

  // Expand one instruction into its cycle steps; fw/mw are wait cycles before mem_ready.
  task automatic pushInstr(input logic [5:0] op, input int fw, input int mw, input int az);
    for (int i = 0; i <= fw; i++) pushStep(0, logic'(i == fw), 1'b0, -1, op);
    pushStep(1, logic'($urandom_range(1)), logic'(!isLegal(op) && !TRAP_BUILD), -1, op);
    case (op)
      LW: begin
        pushStep(2, logic'($urandom_range(1)), 1'b0, -1, op);
        for (int i = 0; i <= mw; i++) pushStep(3, logic'(i == mw), 1'b0, -1, op);
        pushStep(4, logic'($urandom_range(1)), 1'b1, -1, op);
      end
      SW: begin
        pushStep(2, logic'($urandom_range(1)), 1'b0, -1, op);
        for (int i = 0; i <= mw; i++) pushStep(5, logic'(i == mw), logic'(i == mw), -1, op);
      end
      RT: begin
        pushStep(6, 1'b1, 1'b0, -1, op);
        pushStep(7, 1'b1, 1'b1, -1, op);
      end
      ADDI: begin
        pushStep(10, 1'b1, 1'b0, -1, op);
        pushStep(11, 1'b1, 1'b1, -1, op);
      end
      BEQ: pushStep(8, logic'($urandom_range(1)), 1'b1, az, op);
      JMP: pushStep(9, logic'($urandom_range(1)), 1'b1, -1, op);
      default: ;
    endcase
  endtask

  task automatic runTrace();
    while (trace.size() > 0) begin
      step_t s = trace.pop_front();
      @(negedge clk);
      opcode = s.op;
      mem_ready = s.mr;
      alu_zero = s.az;
      #1;
      check("state", 32'(state_out), 32'(s.st));
      check("ctrl", 32'(obsCtrl), 32'(expCtrl(s.st, s.mr, s.az)));
      check("trap", {29'd0, trap, trap_cause}, 32'd0);
      check("count", 32'(instr_count), 32'(modelCount % (1 << CNT_W)));
      if (s.retire) modelCount++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = logic'($urandom_range(1));
    #1;
    check("rst_enables", {27'd0, mem_read, mem_write, ir_write, pc_write, reg_write}, 32'd0);
    @(posedge clk); #1;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_trap", {29'd0, trap, trap_cause}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    modelCount = 0;
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] ops[6];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ; ops[4] = JMP; ops[5] = ADDI;

    doReset();

    // lw, 2 wait cycles in FETCH and MEMRD: states 0,0,0,1,2,3,3,3,4 then 0
    pushInstr(LW, 2, 2, -1);
    runTrace();
    @(posedge clk); #1;
    check("lw_back_to_fetch", 32'(state_out), 32'd0);
    check("lw_count", 32'(instr_count), 32'd1);

    // beq taken and not taken
    pushInstr(BEQ, 0, 0, 1);
    pushInstr(BEQ, 1, 0, 0);
    // R-type then addi, four cycles each
    pushInstr(RT, 0, 0, -1);
    pushInstr(ADDI, 0, 0, -1);
    // mem_ready exactly in the timeout cycle wins
    pushInstr(LW, TMO, TMO, -1);
    pushInstr(SW, TMO, 1, -1);
    runTrace();

    // Reset in the 2nd MEMWR wait cycle
    pushInstr(SW, 0, 5, -1);
    while (trace.size() > 4) void'(trace.pop_back());
    runTrace();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("rst_mid_state", 32'(state_out), 32'd5);
    check("rst_mid_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_next_state", 32'(state_out), 32'd0);
    check("rst_mid_count", 32'(instr_count), 32'd0);
    rst = 1'b0;
    modelCount = 0;

    // Fetch timeout: 4 FETCH cycles without ready, then TRAP
    pushInstr(JMP, 0, 0, -1);
    runTrace();
    for (int i = 0; i <= TMO; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("tmo_fetch_state", 32'(state_out), 32'd0);
      check("tmo_fetch_ir_write", 32'(ir_write), 32'd0);
    end
    @(posedge clk); #1;
    check("tmo_trap_state", 32'(state_out), 32'd12);
    check("tmo_trap_flags", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'b10});
    check("tmo_trap_count", 32'(instr_count), 32'(modelCount));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = logic'($urandom_range(1));
      #1;
      check("trap_stays", 32'(state_out), 32'd12);
      check("trap_ctrl_idle", 32'(obsCtrl), 32'd0);
    end
    doReset();

    // Store timeout: no write in the timeout cycle
    pushInstr(SW, 0, 5, -1);
    while (trace.size() > 6) void'(trace.pop_back());
    runTrace();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("tmo_sw_state", 32'(state_out), 32'd5);
    check("tmo_sw_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    check("tmo_sw_trap", {28'd0, state_out[3:0] == 4'd12, trap, trap_cause}, 32'b1110);
    doReset();

    // Unsupported opcode
    pushInstr(6'b111111, 0, 0, -1);
    runTrace();
    @(posedge clk); #1;
    if (TRAP_BUILD) begin
      check("illegal_state", 32'(state_out), 32'd12);
      check("illegal_cause", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'b01});
      doReset();
    end else begin
      check("illegal_state", 32'(state_out), 32'd0);
      check("illegal_count", 32'(instr_count), 32'd1);
    end

    // Random instruction mix; long enough to wrap the 8-bit counter
    for (int n = 0; n < 300; n++) begin
      if (!TRAP_BUILD && ($urandom_range(15) == 0)) begin
        do op = 6'($urandom); while (isLegal(op));
      end else begin
        op = ops[$urandom_range(5)];
      end
      pushInstr(op, $urandom_range(TMO), $urandom_range(TMO), -1);
      runTrace();
    end
    @(posedge clk); #1;
    check("final_count", 32'(instr_count), 32'(modelCount % (1 << CNT_W)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
